// File: rtl/branch_ctrl_pkg.sv
// Shared encodings and helpers for the ID-stage branch controller.
package branch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 3;
  localparam int unsigned IMMW = 16;
  localparam int unsigned CNTW = 16;

  typedef enum logic [OPW-1:0] {
    CMP_NOP = 3'b000,
    CMP_NE  = 3'b001,
    CMP_GEZ = 3'b010,
    CMP_GTZ = 3'b011,
    CMP_LEZ = 3'b100,
    CMP_LTZ = 3'b101,
    CMP_EQ  = 3'b110
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } br_state_e;

  // Hazard/forward result bundle from br_hazard.
  typedef struct packed {
    logic haz;
    logic fwd_d1;
    logic fwd_d2;
  } haz_res_t;

  function automatic logic op_valid(input logic [OPW-1:0] op);
    return (op != OPW'(CMP_NOP)) && (op != 3'b111);
  endfunction

  // PC+4 plus word offset; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] pc4,
                                                 input logic [IMMW-1:0] imm);
    return pc4 + {{(XLEN-IMMW-2){imm[IMMW-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/br_hazard.sv
// Combinational RAW hazard and MEM-forward detection for branch sources.
module br_hazard
  import branch_ctrl_pkg::*;
(
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic          uses_rt,
  input  logic          ex_we,
  input  logic [RW-1:0] ex_waddr,
  input  logic          mem_we,
  input  logic [RW-1:0] mem_waddr,
  input  logic          mem_load,
  output haz_res_t      res_c
);

  logic rs_nz_c, rt_nz_c;
  logic rs_ex_c, rt_ex_c, rs_mem_c, rt_mem_c;

  always_comb begin
    rs_nz_c  = (rs_addr != '0);
    rt_nz_c  = (rt_addr != '0) && uses_rt;
    rs_ex_c  = rs_nz_c && ex_we  && (rs_addr == ex_waddr);
    rt_ex_c  = rt_nz_c && ex_we  && (rt_addr == ex_waddr);
    rs_mem_c = rs_nz_c && mem_we && (rs_addr == mem_waddr);
    rt_mem_c = rt_nz_c && mem_we && (rt_addr == mem_waddr);

    // Only load data in MEM is too late; ALU results in MEM are forwarded.
    res_c.haz    = rs_ex_c || rt_ex_c || ((rs_mem_c || rt_mem_c) && mem_load);
    res_c.fwd_d1 = rs_mem_c && !mem_load;
    res_c.fwd_d2 = rt_mem_c && !mem_load;
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: hazard stall, resolve FSM, target and counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            BR_VALID,
  input  logic [OPW-1:0]  BR_OP,
  input  logic [RW-1:0]   RS_ADDR,
  input  logic [RW-1:0]   RT_ADDR,
  input  logic            USES_RT,
  input  logic            EX_WE,
  input  logic [RW-1:0]   EX_WADDR,
  input  logic            EX_LOAD,
  input  logic            MEM_WE,
  input  logic [RW-1:0]   MEM_WADDR,
  input  logic            MEM_LOAD,
  input  logic            KILL,
  input  logic [XLEN-1:0] PC4,
  input  logic [IMMW-1:0] IMM16,
  input  logic            RES_CMP,
  output logic [OPW-1:0]  CMP_CTR,
  output logic            FWD_D1,
  output logic            FWD_D2,
  output logic            STALL,
  output logic            REDIRECT,
  output logic [XLEN-1:0] TARGET,
  output logic [CNTW-1:0] BR_CNT,
  output logic [CNTW-1:0] TKN_CNT
);

  haz_res_t hz_c;

  br_hazard u_hazard (
    .rs_addr  (RS_ADDR),
    .rt_addr  (RT_ADDR),
    .uses_rt  (USES_RT),
    .ex_we    (EX_WE),
    .ex_waddr (EX_WADDR),
    .mem_we   (MEM_WE),
    .mem_waddr(MEM_WADDR),
    .mem_load (MEM_LOAD),
    .res_c    (hz_c)
  );

  // EX results never reach ID in time, so loads and ALU ops in EX stall alike.
  logic unused_ex_load;
  assign unused_ex_load = EX_LOAD;

  br_state_e       state_q, state_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [CNTW-1:0] br_cnt_q, br_cnt_d;
  logic [CNTW-1:0] tkn_cnt_q, tkn_cnt_d;
  logic            resolve_c, commit_c, taken_c;

  always_comb begin
    resolve_c = rst_n && BR_VALID && !hz_c.haz;
    commit_c  = resolve_c && !KILL;
    taken_c   = op_valid(BR_OP) && RES_CMP;
  end

  // Next state, sampled taken bit, target and saturating counters.
  always_comb begin
    state_d   = state_q;
    taken_d   = 1'b0;
    target_d  = target_q;
    br_cnt_d  = br_cnt_q;
    tkn_cnt_d = tkn_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_HOLD: begin
        if (!BR_VALID)     state_d = ST_IDLE;
        else if (hz_c.haz) state_d = ST_HOLD;
        else               state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (KILL) state_d = ST_IDLE;

    if (commit_c) begin
      taken_d  = taken_c;
      target_d = br_target(PC4, IMM16);
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNTW'(1);
      if (taken_c && (tkn_cnt_q != '1)) tkn_cnt_d = tkn_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      taken_q   <= 1'b0;
      target_q  <= '0;
      br_cnt_q  <= '0;
      tkn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      br_cnt_q  <= br_cnt_d;
      tkn_cnt_q <= tkn_cnt_d;
    end
  end

  assign CMP_CTR  = (resolve_c && op_valid(BR_OP)) ? BR_OP : OPW'(CMP_NOP);
  assign STALL    = rst_n && BR_VALID && hz_c.haz;
  assign FWD_D1   = rst_n && hz_c.fwd_d1;
  assign FWD_D2   = rst_n && hz_c.fwd_d2;
  assign REDIRECT = taken_q;
  assign TARGET   = target_q;
  assign BR_CNT   = br_cnt_q;
  assign TKN_CNT  = tkn_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: stall/forward, resolve, target wrap, kill, reset, saturation.
module tb_branch_ctrl;

  logic        clk, rst_n;
  logic        br_valid, uses_rt, ex_we, ex_load, mem_we, mem_load, kill, res_cmp;
  logic [2:0]  br_op;
  logic [4:0]  rs_addr, rt_addr, ex_waddr, mem_waddr;
  logic [31:0] pc4;
  logic [15:0] imm16;
  logic [2:0]  cmp_ctr;
  logic        fwd_d1, fwd_d2, stall, redirect;
  logic [31:0] target;
  logic [15:0] br_cnt, tkn_cnt;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .BR_VALID(br_valid), .BR_OP(br_op),
    .RS_ADDR(rs_addr), .RT_ADDR(rt_addr), .USES_RT(uses_rt),
    .EX_WE(ex_we), .EX_WADDR(ex_waddr), .EX_LOAD(ex_load),
    .MEM_WE(mem_we), .MEM_WADDR(mem_waddr), .MEM_LOAD(mem_load),
    .KILL(kill), .PC4(pc4), .IMM16(imm16), .RES_CMP(res_cmp),
    .CMP_CTR(cmp_ctr), .FWD_D1(fwd_d1), .FWD_D2(fwd_d2), .STALL(stall),
    .REDIRECT(redirect), .TARGET(target), .BR_CNT(br_cnt), .TKN_CNT(tkn_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        redirect;
    logic [31:0] target;
    logic [15:0] br_cnt;
    logic [15:0] tkn_cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] m_br, m_tkn;
  logic [31:0] m_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    br_valid = 0; br_op = 0; rs_addr = 0; rt_addr = 0; uses_rt = 0;
    ex_we = 0; ex_waddr = 0; ex_load = 0; mem_we = 0; mem_waddr = 0; mem_load = 0;
    kill = 0; pc4 = 0; imm16 = 0; res_cmp = 0;
  endtask

  task automatic drive_br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic use_rt, input logic [31:0] p, input logic [15:0] imm,
                          input logic res);
    br_valid = 1; br_op = op; rs_addr = rs; rt_addr = rt; uses_rt = use_rt;
    pc4 = p; imm16 = imm; res_cmp = res;
  endtask

  // Model of one resolve cycle; pushes what the registers must show afterwards.
  task automatic expect_resolve(input logic [2:0] op, input logic res, input logic [31:0] p,
                                input logic [15:0] imm, input logic kl);
    exp_t e;
    logic tk;
    tk = (op != 3'b000) && (op != 3'b111) && res && !kl;
    if (!kl) begin
      m_tgt = p + 32'($signed(imm)) * 32'd4;
      if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
      if (tk && m_tkn != 16'hFFFF) m_tkn = m_tkn + 16'd1;
    end
    e.redirect = tk;
    e.target   = m_tgt;
    e.br_cnt   = m_br;
    e.tkn_cnt  = m_tkn;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_redirect"}, 32'(redirect), 32'(e.redirect));
      chk({tag, "_target"},   target,         e.target);
      chk({tag, "_br_cnt"},   32'(br_cnt),    32'(e.br_cnt));
      chk({tag, "_tkn_cnt"},  32'(tkn_cnt),   32'(e.tkn_cnt));
    end
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    m_br = 0; m_tkn = 0; m_tgt = 0;

    // Reset: hazard-looking inputs must not leak to combinational outputs.
    drive_br(3'b110, 5'd8, 5'd8, 1, 32'h1234, 16'h1, 1);
    ex_we = 1; ex_waddr = 8; mem_we = 1; mem_waddr = 8;
    tick(); tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd_d1", 32'(fwd_d1), 0);
    chk("rst_cmp", 32'(cmp_ctr), 0);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_target", target, 0);
    chk("rst_br_cnt", 32'(br_cnt), 0);
    chk("rst_tkn_cnt", 32'(tkn_cnt), 0);
    idle_in();
    rst_n = 1;
    tick();

    // BEQ, no hazard, taken.
    drive_br(3'b110, 5'd1, 5'd2, 1, 32'h0040_0004, 16'h0003, 1);
    @(negedge clk);
    chk("beq_stall", 32'(stall), 0);
    chk("beq_cmp", 32'(cmp_ctr), 32'b110);
    expect_resolve(3'b110, 1, 32'h0040_0004, 16'h0003, 0);
    tick();
    idle_in();
    check_sb("beq");
    chk("beq_target_abs", target, 32'h0040_0010);
    @(negedge clk);
    chk("idle_cmp", 32'(cmp_ctr), 0);
    tick();
    chk("beq_pulse_end", 32'(redirect), 0);

    // BNE, RS=8 with a load in EX: two stall cycles, resolve on the third.
    drive_br(3'b001, 5'd8, 5'd3, 1, 32'h0000_1000, 16'h0010, 1);
    ex_we = 1; ex_waddr = 8; ex_load = 1;
    @(negedge clk);
    chk("bne_stall1", 32'(stall), 1);
    chk("bne_cmp1", 32'(cmp_ctr), 0);
    tick();
    chk("bne_hold_redirect", 32'(redirect), 0);
    ex_we = 0; ex_load = 0; mem_we = 1; mem_waddr = 8; mem_load = 1;
    @(negedge clk);
    chk("bne_stall2", 32'(stall), 1);
    tick();
    mem_we = 0; mem_load = 0;
    @(negedge clk);
    chk("bne_stall3", 32'(stall), 0);
    chk("bne_cmp3", 32'(cmp_ctr), 32'b001);
    expect_resolve(3'b001, 1, 32'h0000_1000, 16'h0010, 0);
    tick();
    idle_in();
    check_sb("bne");

    // BGEZ forwarded from an ALU op in MEM, then a back-to-back BGTZ on r0.
    drive_br(3'b010, 5'd9, 5'd0, 0, 32'h0000_2000, 16'hFFFF, 0);
    mem_we = 1; mem_waddr = 9;
    @(negedge clk);
    chk("bgez_fwd_d1", 32'(fwd_d1), 1);
    chk("bgez_fwd_d2", 32'(fwd_d2), 0);
    chk("bgez_stall", 32'(stall), 0);
    chk("bgez_cmp", 32'(cmp_ctr), 32'b010);
    expect_resolve(3'b010, 0, 32'h0000_2000, 16'hFFFF, 0);
    tick();
    idle_in();
    check_sb("bgez");
    drive_br(3'b011, 5'd0, 5'd0, 0, 32'h0000_3000, 16'h0001, 1);
    ex_we = 1; ex_waddr = 0;
    @(negedge clk);
    chk("r0_stall", 32'(stall), 0);
    chk("r0_cmp", 32'(cmp_ctr), 32'b011);
    expect_resolve(3'b011, 1, 32'h0000_3000, 16'h0001, 0);
    tick();
    idle_in();
    check_sb("bgtz_b2b");

    // RT forwarded from MEM ALU op.
    drive_br(3'b110, 5'd1, 5'd7, 1, 32'h0000_0100, 16'h0000, 0);
    mem_we = 1; mem_waddr = 7;
    @(negedge clk);
    chk("rt_fwd_d2", 32'(fwd_d2), 1);
    chk("rt_fwd_d1", 32'(fwd_d1), 0);
    chk("rt_stall", 32'(stall), 0);
    expect_resolve(3'b110, 0, 32'h0000_0100, 16'h0000, 0);
    tick();
    idle_in();
    check_sb("rt_fwd");

    // Target sign extension and 32-bit wrap; RT ignored when USES_RT=0.
    drive_br(3'b110, 5'd1, 5'd2, 1, 32'h0000_0004, 16'h8000, 1);
    expect_resolve(3'b110, 1, 32'h0000_0004, 16'h8000, 0);
    tick();
    idle_in();
    check_sb("neg_off");
    chk("neg_off_abs", target, 32'hFFFE_0004);
    drive_br(3'b100, 5'd1, 5'd4, 0, 32'hFFFF_FFFC, 16'h0002, 0);
    ex_we = 1; ex_waddr = 4;
    @(negedge clk);
    chk("no_rt_stall", 32'(stall), 0);
    expect_resolve(3'b100, 0, 32'hFFFF_FFFC, 16'h0002, 0);
    tick();
    idle_in();
    check_sb("wrap");
    chk("wrap_abs", target, 32'h0000_0004);

    // KILL in HOLD: no redirect, counters and target unchanged.
    drive_br(3'b001, 5'd5, 5'd6, 1, 32'h0000_5000, 16'h0020, 1);
    ex_we = 1; ex_waddr = 6;
    @(negedge clk);
    chk("kill_stall", 32'(stall), 1);
    tick();
    ex_we = 0; kill = 1;
    expect_resolve(3'b001, 1, 32'h0000_5000, 16'h0020, 1);
    tick();
    idle_in();
    check_sb("kill");

    // Upstream squash in HOLD returns to IDLE without counting.
    drive_br(3'b110, 5'd5, 5'd0, 0, 32'h0000_6000, 16'h0001, 1);
    ex_we = 1; ex_waddr = 5;
    tick();
    idle_in();
    tick();
    chk("squash_redirect", 32'(redirect), 0);
    chk("squash_br_cnt", 32'(br_cnt), 32'(m_br));

    // Reset asserted in DONE drops REDIRECT asynchronously.
    drive_br(3'b110, 5'd1, 5'd2, 1, 32'h0000_7000, 16'h0004, 1);
    expect_resolve(3'b110, 1, 32'h0000_7000, 16'h0004, 0);
    tick();
    idle_in();
    check_sb("pre_rst");
    #1 rst_n = 0;
    #1;
    chk("arst_redirect", 32'(redirect), 0);
    chk("arst_target", target, 0);
    chk("arst_br_cnt", 32'(br_cnt), 0);
    chk("arst_tkn_cnt", 32'(tkn_cnt), 0);
    m_br = 0; m_tkn = 0; m_tgt = 0;
    tick();
    rst_n = 1;
    tick();

    // Invalid BR_OP: not taken, CMP_CTR=000, still counted.
    drive_br(3'b111, 5'd1, 5'd2, 1, 32'h0000_0100, 16'h0004, 1);
    @(negedge clk);
    chk("inv_cmp", 32'(cmp_ctr), 0);
    chk("inv_stall", 32'(stall), 0);
    expect_resolve(3'b111, 1, 32'h0000_0100, 16'h0004, 0);
    tick();
    idle_in();
    check_sb("inv_op");

    // 65537 back-to-back taken resolves saturate both counters.
    drive_br(3'b110, 5'd1, 5'd2, 1, 32'h0000_0000, 16'h0001, 1);
    for (int i = 0; i < 65537; i++) begin
      tick();
      if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
      if (m_tkn != 16'hFFFF) m_tkn = m_tkn + 16'd1;
    end
    idle_in();
    chk("sat_br_model", 32'(br_cnt), 32'(m_br));
    chk("sat_br_cnt", 32'(br_cnt), 32'hFFFF);
    chk("sat_tkn_cnt", 32'(tkn_cnt), 32'hFFFF);
    chk("sat_redirect", 32'(redirect), 1);
    tick();
    chk("sat_pulse_end", 32'(redirect), 0);

    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, listed first: clk in 1 (rising-edge clock); rst_n in 1 (asynchronous active-low reset).
REQ-002 It SHALL have these ports, one per line (name direction width meaning):
- BR_VALID in 1: branch instruction present in ID.
- BR_OP in 3: condition code; 110 EQ, 001 NE, 010 GEZ, 011 GTZ, 100 LEZ, 101 LTZ; 000/111 invalid.
- RS_ADDR in 5: first comparator source register.
- RT_ADDR in 5: second source register.
- USES_RT in 1: branch reads RT (EQ/NE).
- EX_WE in 1: EX-stage register write enable.
- EX_WADDR in 5: EX destination.
- EX_LOAD in 1: EX instruction is a load.
- MEM_WE in 1: MEM-stage write enable.
- MEM_WADDR in 5: MEM destination.
- MEM_LOAD in 1: MEM instruction is a load.
- KILL in 1: synchronous abort of the in-flight branch (exception/flush).
- PC4 in 32: branch PC+4.
- IMM16 in 16: branch offset in words.
- RES_CMP in 1: comparator result.
- CMP_CTR out 3: comparator condition select.
- FWD_D1 out 1: select MEM result for D1.
- FWD_D2 out 1: select MEM result for D2.
- STALL out 1: freeze IF/ID.
- REDIRECT out 1: one-cycle pulse that loads TARGET into the PC.
- TARGET out 32: registered branch target.
- BR_CNT out 16: resolved-branch count.
- TKN_CNT out 16: taken-branch count.

Function
REQ-003 An FSM SHALL have states IDLE, HOLD and DONE.
REQ-004 A register is hazardous when it is nonzero and matches EX_WADDR with EX_WE=1, or matches MEM_WADDR with MEM_WE=1 and MEM_LOAD=1; RT SHALL be checked only when USES_RT=1.
REQ-005 A non-load MEM match on a nonzero register SHALL NOT stall; it SHALL assert FWD_D1 (RS) or FWD_D2 (RT).
REQ-006 In IDLE or DONE with BR_VALID=1 and a hazard: STALL=1, CMP_CTR=000, next state HOLD.
REQ-007 In HOLD: STALL=1 while the hazard persists; the first hazard-free cycle SHALL resolve with STALL=0.
REQ-008 Resolve cycle (IDLE/DONE/HOLD with BR_VALID=1 and no hazard): CMP_CTR=BR_OP; RES_CMP sampled at the edge; next state DONE.
REQ-009 In DONE, REDIRECT SHALL equal the sampled taken bit for exactly one cycle, giving a latency of 1 cycle from resolve.
REQ-010 TARGET SHALL be registered at resolve as PC4 + (sign-extended IMM16 << 2), modulo 2^32 (wrap, no flag).
REQ-011 An invalid BR_OP SHALL resolve as not-taken, drive CMP_CTR=000, and still count in BR_CNT.
REQ-012 Outside the resolve cycle, CMP_CTR SHALL be 000.
REQ-013 STALL, FWD_D1 and FWD_D2 SHALL be combinational.
REQ-014 At resolve, BR_CNT SHALL increment, and TKN_CNT SHALL increment if taken; both saturate at 0xFFFF.
REQ-015 KILL=1 SHALL force the next state to IDLE, suppress the REDIRECT of any resolve in that cycle, and suppress counting; it has priority over BR_VALID.
REQ-016 BR_VALID=0 in HOLD (upstream squash) SHALL return the FSM to IDLE without counting.
REQ-017 A branch presented in DONE (back-to-back) SHALL be handled as in IDLE while the previous REDIRECT pulse completes.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously clear state to IDLE and set REDIRECT=0, TARGET=0, BR_CNT=0, TKN_CNT=0 and the taken register to 0.
REQ-019 Combinational outputs SHALL be 0 during reset regardless of inputs.
REQ-020 Reset deassertion SHALL take effect at the next clk edge.

Structure
REQ-021 A shared package SHALL hold the BR_OP/CMP_CTR encodings (CMP_EQ=110, CMP_NE=001, CMP_GEZ=010, CMP_GTZ=011, CMP_LEZ=100, CMP_LTZ=101, CMP_NOP=000) and the FSM state encoding.
REQ-022 Hazard and forward detection SHALL be the combinational sub-module br_hazard; the FSM, target and counters SHALL stay in branch_ctrl.

Verification
REQ-023 The bench SHALL cover: BEQ, no hazard, RES_CMP=1, PC4=0x00400004, IMM16=0x0003 -> CMP_CTR=110 in the resolve cycle, REDIRECT=1 next cycle, TARGET=0x00400010, BR_CNT=1, TKN_CNT=1.
REQ-024 The bench SHALL cover: BNE with RS=8 while EX is a load writing r8 -> STALL=1 for 2 cycles, resolve in the 3rd cycle, REDIRECT follows RES_CMP.
REQ-025 The bench SHALL cover: BGEZ with RS=9 while MEM is an ALU op writing r9 -> FWD_D1=1, STALL=0, resolve in the same cycle; RS=0 with EX writing r0 -> no stall.
REQ-026 The bench SHALL cover: IMM16=0x8000, PC4=0x00000004 -> TARGET=0xFFFE0004; PC4=0xFFFFFFFC, IMM16=0x0002 -> TARGET=0x00000004.
REQ-027 The bench SHALL cover: KILL asserted in HOLD -> IDLE, no REDIRECT, counters unchanged; rst_n pulsed low in DONE -> REDIRECT drops immediately.
REQ-028 The bench SHALL cover: 65537 taken resolves -> BR_CNT=TKN_CNT=0xFFFF; BR_OP=111 -> not taken, CMP_CTR=000, BR_CNT+1 only.
